// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 from a 100 MHz system clock) and a
// counter-width helper used by the display core.
package vga_timing_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  localparam int HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int HS_END   = HS_START + VGA_H_SYNC;
  localparam int VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VS_END   = VS_START + VGA_V_SYNC;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that realigns sync/blank with the pixel
// generator latency; DEPTH=0 degenerates to plain wires.
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_100MHz, reset, en};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk_100MHz) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_display_core.sv
// VGA back-end: pixel-tick divider, H/V counters, sync generation and the
// registered output stage aligned to the pixel generator's latency.
module vga_display_core
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_POL    = VGA_SYNC_POL,
  parameter int COLOR_W     = 4,
  parameter int PIPE_STAGES = 0,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW         = cnt_width(H_TOTAL),
  localparam int YW         = cnt_width(V_TOTAL)
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic               p_tick,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               video_on,
  output logic               frame_end,
  output logic               hsync,
  output logic               vsync,
  output logic [3*COLOR_W-1:0] rgb
);

  generate
    if (CLK_DIV < 1 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        PIPE_STAGES < 0 || PIPE_STAGES > 15) begin : g_bad_params
      $error("vga_display_core: invalid timing parameters");
    end
  endgenerate

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS     = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE     = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS     = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE     = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          h_wrap, v_wrap;
  logic          hs_raw, vs_raw;
  logic [2:0]    dl_q;
  logic          d_hs, d_vs, d_vid;

  always_ff @(posedge clk_100MHz) begin
    if (reset || div == DIV_LAST) div <= '0;
    else                          div <= div + 1'b1;
  end

  assign p_tick = (div == DIV_LAST) && !reset;
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
    end
  end

  assign x         = h;
  assign y         = v;
  assign video_on  = (h < H_VIS) && (v < V_VIS);
  assign frame_end = p_tick && h_wrap && v_wrap;
  assign hs_raw    = (h >= H_SS && h < H_SE) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw    = (v >= V_SS && v < V_SE) ? SYNC_POL : ~SYNC_POL;

  // Sync and blank wait here for the colour the pixel generator is still computing.
  vga_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_STAGES),
    .RESET_VAL({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_delay (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .en        (p_tick),
    .d         ({hs_raw, vs_raw, video_on}),
    .q         (dl_q)
  );

  assign {d_hs, d_vs, d_vid} = dl_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      rgb   <= '0;
    end else if (p_tick) begin
      hsync <= d_hs;
      vsync <= d_vs;
      rgb   <= d_vid ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_display_core.sv
// Bench for vga_display_core: two reduced-timing instances (divided clock with
// a 2-stage pixel pipeline, and undivided with no pipeline and active-high sync).
module tb_vga_display_core;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vid;
    logic [11:0] col;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0]   i_rgb [2];
  logic          o_pt  [2];
  logic [XW-1:0] o_x   [2];
  logic [YW-1:0] o_y   [2];
  logic          o_vo  [2];
  logic          o_fe  [2];
  logic          o_hs  [2];
  logic          o_vs  [2];
  logic [11:0]   o_rgb [2];

  always #5 clk = ~clk;

  vga_display_core #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .COLOR_W(4), .PIPE_STAGES(2)
  ) dut_a (
    .clk_100MHz(clk), .reset(reset), .rgb_in(i_rgb[0]), .p_tick(o_pt[0]),
    .x(o_x[0]), .y(o_y[0]), .video_on(o_vo[0]), .frame_end(o_fe[0]),
    .hsync(o_hs[0]), .vsync(o_vs[0]), .rgb(o_rgb[0])
  );

  vga_display_core #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b1), .COLOR_W(4), .PIPE_STAGES(0)
  ) dut_b (
    .clk_100MHz(clk), .reset(reset), .rgb_in(i_rgb[1]), .p_tick(o_pt[1]),
    .x(o_x[1]), .y(o_y[1]), .video_on(o_vo[1]), .frame_end(o_fe[1]),
    .hsync(o_hs[1]), .vsync(o_vs[1]), .rgb(o_rgb[1])
  );

  int   checks = 0, errors = 0;
  bit   chk_en = 0, solid = 0, cnt_on = 0;
  int   m_div [2], m_h [2], m_v [2];
  logic m_hs [2], m_vs [2];
  logic [11:0] m_rgb [2];
  sb_t  sbq [2][$];
  int   rel_cyc = 0;
  int   first_pt [2], fe_first [2];
  int   fe_at [$];
  int   hs_run = 0, hs_tot = 0, hs_bad = 0, vs_run = 0, vs_tot = 0, vs_bad = 0;
  int   fff_cnt = 0;

  function automatic int p_div(input int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int p_pipe(input int d); return (d == 0) ? 2 : 0; endfunction
  function automatic logic p_pol(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction

  function automatic logic [11:0] colour(input int h, input int v);
    return solid ? 12'hFFF : {4'(h), 4'(v), 4'hA};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One system clock: drive on the falling edge, compare, then advance the model
  // on the rising edge. Expected outputs travel through a per-instance queue.
  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    if (r) rel_cyc = 0;
    else   rel_cyc++;
    for (int d = 0; d < 2; d++) begin
      logic tk;
      logic [11:0] want;
      tk = !r && (m_div[d] == p_div(d) - 1);
      want = 12'h0;
      if (p_pipe(d) == 0)        want = colour(m_h[d], m_v[d]);
      else if (sbq[d].size() > 0) want = sbq[d][0].col;
      i_rgb[d] = tk ? want : 12'($urandom);
    end
    #1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic tk;
        tk = !r && (m_div[d] == p_div(d) - 1);
        chk($sformatf("p_tick%0d", d), 32'(o_pt[d]), 32'(tk));
        chk($sformatf("x%0d", d), 32'(o_x[d]), m_h[d]);
        chk($sformatf("y%0d", d), 32'(o_y[d]), m_v[d]);
        chk($sformatf("video_on%0d", d), 32'(o_vo[d]), 32'(m_h[d] < HA && m_v[d] < VA));
        chk($sformatf("frame_end%0d", d), 32'(o_fe[d]),
            32'(tk && m_h[d] == HT - 1 && m_v[d] == VT - 1));
        chk($sformatf("hsync%0d", d), 32'(o_hs[d]), 32'(m_hs[d]));
        chk($sformatf("vsync%0d", d), 32'(o_vs[d]), 32'(m_vs[d]));
        chk($sformatf("rgb%0d", d), 32'(o_rgb[d]), 32'(m_rgb[d]));
        if (!r && o_pt[d] === 1'b1 && first_pt[d] < 0) first_pt[d] = rel_cyc;
        if (!r && o_fe[d] === 1'b1 && fe_first[d] < 0) fe_first[d] = rel_cyc;
      end
      if (o_fe[0] === 1'b1) fe_at.push_back(rel_cyc);
      if (o_hs[0] === 1'b0) hs_run++;
      else if (hs_run != 0) begin
        hs_tot++;
        if (hs_run != HSW * 2) hs_bad++;
        hs_run = 0;
      end
      if (o_vs[0] === 1'b0) vs_run++;
      else if (vs_run != 0) begin
        vs_tot++;
        if (vs_run != VSW * HT * 2) vs_bad++;
        vs_run = 0;
      end
      if (cnt_on && o_rgb[1] === 12'hFFF) fff_cnt++;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      sb_t e;
      logic pol;
      pol = p_pol(d);
      if (r) begin
        m_div[d] = 0; m_h[d] = 0; m_v[d] = 0;
        m_hs[d] = !pol; m_vs[d] = !pol; m_rgb[d] = 12'h0;
        first_pt[d] = -1; fe_first[d] = -1;
        sbq[d].delete();
        e.hs = !pol; e.vs = !pol; e.vid = 1'b0; e.col = 12'h0;
        repeat (p_pipe(d)) sbq[d].push_back(e);
      end else if (m_div[d] == p_div(d) - 1) begin
        e.hs  = (m_h[d] >= HA + HFP && m_h[d] < HA + HFP + HSW) ? pol : !pol;
        e.vs  = (m_v[d] >= VA + VFP && m_v[d] < VA + VFP + VSW) ? pol : !pol;
        e.vid = (m_h[d] < HA && m_v[d] < VA);
        e.col = colour(m_h[d], m_v[d]);
        sbq[d].push_back(e);
        e = sbq[d].pop_front();
        m_hs[d] = e.hs; m_vs[d] = e.vs; m_rgb[d] = e.vid ? e.col : 12'h0;
        m_div[d] = 0;
        if (m_h[d] == HT - 1) begin
          m_h[d] = 0;
          m_v[d] = (m_v[d] == VT - 1) ? 0 : m_v[d] + 1;
        end else begin
          m_h[d]++;
        end
      end else begin
        m_div[d]++;
      end
    end
  endtask

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      i_rgb[d] = 12'h0; m_div[d] = 0; m_h[d] = 0; m_v[d] = 0;
      m_hs[d] = 1'b1; m_vs[d] = 1'b1; m_rgb[d] = 12'h0;
      first_pt[d] = -1; fe_first[d] = -1;
    end

    // Reset held for 10 cycles; checking starts once registers are defined.
    step(1); step(1);
    chk_en = 1;
    repeat (8) step(1);

    // Two full frames of the gradient pattern.
    repeat (2 * HT * VT * 2 + 20) step(0);
    chk("first_ptick_a", first_pt[0], 2);
    chk("first_ptick_b", first_pt[1], 1);
    chk("frame_end_a_first", fe_first[0], HT * VT * 2);
    chk("frame_end_b_first", fe_first[1], HT * VT);
    chk("frame_end_a_count", fe_at.size(), 2);
    if (fe_at.size() >= 2) chk("frame_period_a", fe_at[1] - fe_at[0], HT * VT * 2);
    chk("hsync_runs_seen", 32'(hs_tot >= 2 * VT - 1), 1);
    chk("hsync_width_bad", hs_bad, 0);
    chk("vsync_runs_seen", 32'(vs_tot >= 2), 1);
    chk("vsync_width_bad", vs_bad, 0);

    // Solid white: exactly the visible area shows colour over one whole frame.
    solid = 1;
    repeat (5) step(0);
    cnt_on = 1;
    repeat (HT * VT) step(0);
    cnt_on = 0;
    chk("white_pixels_per_frame", fff_cnt, HA * VA);
    repeat (HT * VT * 2) step(0);
    solid = 0;

    // One-cycle reset mid-line, then the next frame_end lands a full frame later.
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (m_h[0] == 10 && m_v[0] == 3) found = 1;
      else step(0);
    end
    chk("reach_midline", 32'(found), 1);
    step(1);
    repeat (HT * VT * 2 + 10) step(0);
    chk("frame_end_a_after_reset", fe_first[0], HT * VT * 2);
    chk("frame_end_b_after_reset", fe_first[1], HT * VT);
    chk("first_ptick_a_after_reset", first_pt[0], 2);
    chk("hsync_width_bad_end", hs_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
